// File: rtl/tone_sequencer_if.sv
// Command/status bundle between the tone sequencer and its controller.
interface tone_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [3:0]    btn_stable;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic [31:0]   freq_div;
  logic [1:0]    state;
  logic [CW-1:0] rec_count;
  logic [IW-1:0] play_idx;
  logic          overflow;
  logic          done;

  modport master (
    output btn_stable, rec_start, play_start, stop,
    input  freq_div, state, rec_count, play_idx, overflow, done
  );

  modport slave (
    input  btn_stable, rec_start, play_start, stop,
    output freq_div, state, rec_count, play_idx, overflow, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Record/playback controller owning the half-period divisor for the tone generator.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | live keys drive freq_div, waits for rec/play commands
// REC   (1) | live keys drive freq_div, each new press is stored
// NOTE  (2) | plays buffer[play_idx] for NOTE_CYC cycles
// GAP   (3) | silence for GAP_CYC cycles, then next note or finish
module tone_sequencer #(
  parameter int          CLK_HZ  = 25_000_000,
  parameter int          NOTE_MS = 250,
  parameter int          GAP_MS  = 50,
  parameter int          DEPTH   = 16,
  parameter logic [31:0] DIV_DO  = 32'd23860,
  parameter logic [31:0] DIV_RE  = 32'd21302,
  parameter logic [31:0] DIV_MI  = 32'd18977,
  parameter logic [31:0] DIV_FA  = 32'd17906
) (
  input logic             clk,
  input logic             rst_n,
  tone_sequencer_if.slave bus
);
  localparam int NOTE_CYC = (CLK_HZ / 1000) * NOTE_MS;
  localparam int GAP_RAW  = (CLK_HZ / 1000) * GAP_MS;
  localparam int GAP_CYC  = (GAP_RAW == 0) ? 1 : GAP_RAW;
  localparam int TMR_MAX  = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int TW       = $clog2(TMR_MAX + 1);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int IW       = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_NOTE = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [31:0]   freq_q, freq_d;
  logic [3:0]    btn_prev_q;
  logic [1:0]    mem_q [DEPTH];
  logic [3:0]    new_keys;
  logic          wr_en;

  function automatic logic [1:0] low_code(input logic [3:0] b);
    if (b[0])      return 2'd0;
    else if (b[1]) return 2'd1;
    else if (b[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [31:0] div_of(input logic [1:0] code);
    case (code)
      2'd0:    return DIV_DO;
      2'd1:    return DIV_RE;
      2'd2:    return DIV_MI;
      default: return DIV_FA;
    endcase
  endfunction

  assign new_keys = bus.btn_stable & ~btn_prev_q;

  // Next-state, command arbitration (stop > rec_start > play_start) and timer.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.rec_start) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_REC;
        end else if (bus.play_start) begin
          if (cnt_q != '0) begin
            idx_d   = '0;
            tmr_d   = TW'(NOTE_CYC - 1);
            state_d = S_NOTE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REC: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.rec_start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (new_keys != 4'd0) begin
          if (cnt_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_NOTE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (tmr_q == '0) begin
          tmr_d   = TW'(GAP_CYC - 1);
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (tmr_q == '0) begin
          if (CW'(idx_q) == cnt_q - CW'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            tmr_d   = TW'(NOTE_CYC - 1);
            state_d = S_NOTE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
    endcase
  end

  // Divisor follows the next state so it lines up with the state register.
  always_comb begin
    freq_d = 32'd0;
    case (state_d)
      S_IDLE, S_REC: freq_d = (bus.btn_stable == 4'd0) ? 32'd0 : div_of(low_code(bus.btn_stable));
      S_NOTE:        freq_d = div_of(mem_q[idx_d]);
      default:       freq_d = 32'd0;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= 32'd0;
      btn_prev_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
      btn_prev_q <= bus.btn_stable;
    end
  end

  // Melody storage; not reset, rec_count alone marks valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[IW-1:0]] <= low_code(new_keys);
  end

  assign bus.freq_div  = freq_q;
  assign bus.state     = state_q;
  assign bus.rec_count = cnt_q;
  assign bus.play_idx  = idx_q;
  assign bus.overflow  = ovf_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: 4 kHz clock, 8-cycle notes, 4-cycle gaps, 4-entry buffer.
module tb_tone_sequencer;
  localparam logic [31:0] DDO = 32'd23860;
  localparam logic [31:0] DRE = 32'd21302;
  localparam logic [31:0] DMI = 32'd18977;
  localparam logic [31:0] DFA = 32'd17906;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  tone_sequencer_if #(.DEPTH(4)) bus();

  tone_sequencer #(
    .CLK_HZ(4000), .NOTE_MS(2), .GAP_MS(1), .DEPTH(4),
    .DIV_DO(DDO), .DIV_RE(DRE), .DIV_MI(DMI), .DIV_FA(DFA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    bus.btn_stable = b;
    step();
    bus.btn_stable = 4'd0;
    step();
  endtask

  task automatic cmd_rec();
    bus.rec_start = 1'b1; step(); bus.rec_start = 1'b0;
  endtask

  task automatic cmd_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_stable = 4'd0; bus.rec_start = 1'b0; bus.play_start = 1'b0; bus.stop = 1'b0;
    rst_n = 1'b0;
    #12;
    chk_cnt++; if (bus.freq_div !== 32'd0) $display("FAIL reset_freq got %0d want 0", bus.freq_div); else pass_cnt++;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.state); else pass_cnt++;
    chk_cnt++; if (bus.rec_count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.rec_count); else pass_cnt++;
    chk_cnt++; if (bus.play_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", bus.play_idx); else pass_cnt++;
    chk_cnt++; if (bus.overflow !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags got %b%b want 00", bus.overflow, bus.done); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_live_priority();
    bus.btn_stable = 4'b0110; exp_q.push_back(DRE);
    step();
    e = exp_q.pop_front();
    chk_cnt++; if (bus.freq_div !== e) $display("FAIL live_0110 got %0d want %0d", bus.freq_div, e); else pass_cnt++;
    bus.btn_stable = 4'b1000; exp_q.push_back(DFA);
    step();
    e = exp_q.pop_front();
    chk_cnt++; if (bus.freq_div !== e) $display("FAIL live_1000 got %0d want %0d", bus.freq_div, e); else pass_cnt++;
    bus.btn_stable = 4'b0000; exp_q.push_back(32'd0);
    step();
    e = exp_q.pop_front();
    chk_cnt++; if (bus.freq_div !== e) $display("FAIL live_none got %0d want %0d", bus.freq_div, e); else pass_cnt++;
  endtask

  // Push the whole expected freq_div trace for a melody, then compare cycle by cycle.
  task automatic play_and_check(input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2, input int notes);
    logic [31:0] nd [3];
    int total;
    nd[0] = n0; nd[1] = n1; nd[2] = n2;
    for (int n = 0; n < notes; n++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(nd[n]);
      for (int k = 0; k < 4; k++) exp_q.push_back(32'd0);
    end
    exp_q.push_back(32'd0);
    total = notes * 12 + 1;
    bus.play_start = 1'b1; step(); bus.play_start = 1'b0;
    for (int i = 0; i < total; i++) begin
      e = exp_q.pop_front();
      chk_cnt++; if (bus.freq_div !== e) $display("FAIL play_freq[%0d] got %0d want %0d", i, bus.freq_div, e); else pass_cnt++;
      chk_cnt++; if (bus.done !== (i == total - 1)) $display("FAIL play_done[%0d] got %b want %b", i, bus.done, (i == total - 1)); else pass_cnt++;
      if (i == total - 1) begin
        chk_cnt++; if (bus.state !== 2'd0) $display("FAIL play_end_state got %0d want 0", bus.state); else pass_cnt++;
      end
      step();
    end
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL done_width got %b want 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_record_playback();
    cmd_rec();
    chk_cnt++; if (bus.state !== 2'd1) $display("FAIL rec_state got %0d want 1", bus.state); else pass_cnt++;
    press(4'b0100);
    press(4'b0001);
    press(4'b1000);
    cmd_stop();
    chk_cnt++; if (bus.rec_count !== 3'd3) $display("FAIL rec_count got %0d want 3", bus.rec_count); else pass_cnt++;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL rec_stop_state got %0d want 0", bus.state); else pass_cnt++;
    play_and_check(DMI, DDO, DFA, 3);
    chk_cnt++; if (bus.play_idx !== 2'd2) $display("FAIL play_idx_end got %0d want 2", bus.play_idx); else pass_cnt++;
  endtask

  task automatic test_overflow();
    cmd_rec();
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", bus.overflow); else pass_cnt++;
    press(4'b0001);
    chk_cnt++; if (bus.rec_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", bus.rec_count); else pass_cnt++;
    chk_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", bus.overflow); else pass_cnt++;
    cmd_rec();
    chk_cnt++; if (bus.rec_count !== 3'd0) $display("FAIL ovf_clr_count got %0d want 0", bus.rec_count); else pass_cnt++;
    chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr_flag got %b want 0", bus.overflow); else pass_cnt++;
    cmd_stop();
  endtask

  task automatic test_simultaneous_and_stop();
    cmd_rec();
    press(4'b1010);
    cmd_stop();
    chk_cnt++; if (bus.rec_count !== 3'd1) $display("FAIL simul_count got %0d want 1", bus.rec_count); else pass_cnt++;
    exp_q.push_back(DRE);
    bus.play_start = 1'b1; step(); bus.play_start = 1'b0;
    e = exp_q.pop_front();
    chk_cnt++; if (bus.freq_div !== e) $display("FAIL simul_code got %0d want %0d", bus.freq_div, e); else pass_cnt++;
    step(); step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL stop_play_state got %0d want 0", bus.state); else pass_cnt++;
    chk_cnt++; if (bus.freq_div !== 32'd0) $display("FAIL stop_play_freq got %0d want 0", bus.freq_div); else pass_cnt++;
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL stop_play_done got %b want 0", bus.done); else pass_cnt++;
    step();
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL stop_play_done2 got %b want 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_conflicts();
    bus.stop = 1'b1; bus.play_start = 1'b1; step(); bus.stop = 1'b0; bus.play_start = 1'b0;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL stop_vs_play_state got %0d want 0", bus.state); else pass_cnt++;
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL stop_vs_play_done got %b want 0", bus.done); else pass_cnt++;
    cmd_rec();
    cmd_stop();
    bus.play_start = 1'b1; step(); bus.play_start = 1'b0;
    chk_cnt++; if (bus.done !== 1'b1) $display("FAIL empty_done got %b want 1", bus.done); else pass_cnt++;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL empty_state got %0d want 0", bus.state); else pass_cnt++;
    step();
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL empty_done_width got %b want 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_play();
    cmd_rec();
    press(4'b0100);
    press(4'b0010);
    cmd_stop();
    bus.play_start = 1'b1; step(); bus.play_start = 1'b0;
    step(); step();
    chk_cnt++; if (bus.state !== 2'd2 || bus.freq_div !== DMI) $display("FAIL pre_rst got state %0d freq %0d want 2 %0d", bus.state, bus.freq_div, DMI); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.freq_div !== 32'd0) $display("FAIL async_rst_freq got %0d want 0", bus.freq_div); else pass_cnt++;
    chk_cnt++; if (bus.state !== 2'd0) $display("FAIL async_rst_state got %0d want 0", bus.state); else pass_cnt++;
    chk_cnt++; if (bus.rec_count !== 3'd0) $display("FAIL async_rst_count got %0d want 0", bus.rec_count); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk_cnt++; if (bus.state !== 2'd0 || bus.freq_div !== 32'd0) $display("FAIL post_rst got state %0d freq %0d want 0 0", bus.state, bus.freq_div); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_live_priority();
    test_record_playback();
    test_overflow();
    test_simultaneous_and_stop();
    test_conflicts();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
